// File: rtl/load_align_unit_if.sv
// -----------------------------------------------------------------------------
// load_align_unit_if
// Handshake/bus bundle between data-memory read data, the load align unit and
// the writeback stage.
//   master : producer/consumer side (drives load requests and out_ready)
//   slave  : load_align_unit side (drives in_ready and the aligned result)
// Signals:
//   in_valid / in_ready     : load request handshake
//   mem_out [DATA_W]        : raw memory word
//   L_S_SL  [3]             : load mode (0 NONE,1 B,2 BU,3 H,4 HU,5 W,6 WU,7 D)
//   DMAddr  [OFF_W]         : byte offset within the word
//   in_tag  [TAG_W]         : destination register tag
//   out_valid / out_ready   : result handshake
//   DM_data [DATA_W]        : extended load data
//   out_tag [TAG_W]         : tag of the presented result
//   exc_adel                : address error on load for the presented result
// DATA_W and TAG_W must match the parameters of the attached load_align_unit.
// -----------------------------------------------------------------------------
interface load_align_unit_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] mem_out;
   logic [2:0]        L_S_SL;
   logic [OFF_W-1:0]  DMAddr;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] DM_data;
   logic [TAG_W-1:0]  out_tag;
   logic              exc_adel;

   modport master (
      output in_valid, mem_out, L_S_SL, DMAddr, in_tag, out_ready,
      input  in_ready, out_valid, DM_data, out_tag, exc_adel
   );

   modport slave (
      input  in_valid, mem_out, L_S_SL, DMAddr, in_tag, out_ready,
      output in_ready, out_valid, DM_data, out_tag, exc_adel
   );
endinterface

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
// Registered load alignment between data-memory read data and writeback.
// Selects a byte/half/word/double lane of the memory word, sign- or
// zero-extends it, flags misaligned/illegal loads, and passes results through
// a 2-entry FIFO (output register + skid register) with valid/ready.
// Parameters:
//   DATA_W : 32 or 64 (memory/register width)
//   TAG_W  : destination-register tag width
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   flush  : synchronous flush, invalidates both entries (overrides accept)
//   bus    : load_align_unit_if.slave (request and result handshakes)
//   load_cnt / adel_cnt [16] : only with LOAD_ALIGN_PERF_EN defined;
//            saturating counts of popped non-NONE loads and popped
//            address-error loads. Cleared by reset only.
// Optional feature macro: LOAD_ALIGN_PERF_EN
// -----------------------------------------------------------------------------
module load_align_unit #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   load_align_unit_if.slave bus
`ifdef LOAD_ALIGN_PERF_EN
   ,
   output logic [15:0]      load_cnt,
   output logic [15:0]      adel_cnt
`endif
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_B    = 3'd1;
   localparam logic [2:0] MODE_BU   = 3'd2;
   localparam logic [2:0] MODE_H    = 3'd3;
   localparam logic [2:0] MODE_HU   = 3'd4;
   localparam logic [2:0] MODE_W    = 3'd5;
   localparam logic [2:0] MODE_WU   = 3'd6;
   localparam logic [2:0] MODE_D    = 3'd7;

   // Offset masks that round the byte offset down to a half/word boundary.
   // For DATA_W=32 the word mask is zero, so words always come from lane 0.
   localparam logic [OFF_W-1:0] HALF_MASK = OFF_W'(32'hFFFF_FFFE);
   localparam logic [OFF_W-1:0] WORD_MASK = OFF_W'(32'hFFFF_FFFC);

   // Alignment results (combinational, ahead of storage)
   logic [OFF_W-1:0]  half_off_s;
   logic [OFF_W-1:0]  word_off_s;
   logic [7:0]        byte_lane_s;
   logic [15:0]       half_lane_s;
   logic [31:0]       word_lane_s;
   logic [DATA_W-1:0] align_data_s;
   logic              align_exc_s;

   // Storage: entry 0 drives the outputs, entry 1 is the skid
   logic [DATA_W-1:0] data0_r, data1_r, data0_s, data1_s;
   logic [TAG_W-1:0]  tag0_r,  tag1_r,  tag0_s,  tag1_s;
   logic              exc0_r,  exc1_r,  exc0_s,  exc1_s;
   logic              valid0_r, valid1_r, valid0_s, valid1_s;
   logic              accept_s;
   logic              pop_s;

   // Lane extraction and extension/exception decode for the incoming load
   always_comb begin
      half_off_s   = bus.DMAddr & HALF_MASK;
      word_off_s   = bus.DMAddr & WORD_MASK;
      byte_lane_s  = 8'(bus.mem_out >> {bus.DMAddr, 3'b000});
      half_lane_s  = 16'(bus.mem_out >> {half_off_s, 3'b000});
      word_lane_s  = 32'(bus.mem_out >> {word_off_s, 3'b000});
      align_data_s = {DATA_W{1'b0}};
      align_exc_s  = 1'b0;
      case (bus.L_S_SL)
         MODE_NONE: begin
            align_data_s = {DATA_W{1'b0}};
         end
         MODE_B:  align_data_s = DATA_W'($signed(byte_lane_s));
         MODE_BU: align_data_s = DATA_W'(byte_lane_s);
         MODE_H, MODE_HU: begin
            if (bus.DMAddr[0] != 1'b0) begin
               align_exc_s = 1'b1;
            end else if (bus.L_S_SL == MODE_H) begin
               align_data_s = DATA_W'($signed(half_lane_s));
            end else begin
               align_data_s = DATA_W'(half_lane_s);
            end
         end
         MODE_W: begin
            if (bus.DMAddr[1:0] != 2'b00) begin
               align_exc_s = 1'b1;
            end else begin
               align_data_s = DATA_W'($signed(word_lane_s));
            end
         end
         MODE_WU: begin
            // A 32-bit machine has no zero-extending word load
            if ((DATA_W == 32) || (bus.DMAddr[1:0] != 2'b00)) begin
               align_exc_s = 1'b1;
            end else begin
               align_data_s = DATA_W'(word_lane_s);
            end
         end
         MODE_D: begin
            if ((DATA_W == 32) || (bus.DMAddr != {OFF_W{1'b0}})) begin
               align_exc_s = 1'b1;
            end else begin
               align_data_s = bus.mem_out;
            end
         end
         default: begin
            align_data_s = {DATA_W{1'b0}};
            align_exc_s  = 1'b0;
         end
      endcase
   end

   // in_ready depends on registered skid state only
   assign accept_s = bus.in_valid && !valid1_r;
   assign pop_s    = valid0_r && bus.out_ready;

`ifdef LOAD_ALIGN_PERF_EN
   logic ld0_r, ld1_r, ld0_s, ld1_s;
`endif

   // Next-state of the 2-entry FIFO
   always_comb begin
      data0_s  = data0_r;
      tag0_s   = tag0_r;
      exc0_s   = exc0_r;
      valid0_s = valid0_r;
      data1_s  = data1_r;
      tag1_s   = tag1_r;
      exc1_s   = exc1_r;
      valid1_s = valid1_r;
`ifdef LOAD_ALIGN_PERF_EN
      ld0_s    = ld0_r;
      ld1_s    = ld1_r;
`endif
      if (flush) begin
         valid0_s = 1'b0;
         valid1_s = 1'b0;
      end else if (!valid0_r || pop_s) begin
         // Entry 0 frees up: the skid (older) takes priority over new data.
         // accept_s is 0 whenever the skid is full.
         if (valid1_r) begin
            data0_s  = data1_r;
            tag0_s   = tag1_r;
            exc0_s   = exc1_r;
            valid0_s = 1'b1;
            valid1_s = 1'b0;
`ifdef LOAD_ALIGN_PERF_EN
            ld0_s    = ld1_r;
`endif
         end else if (accept_s) begin
            data0_s  = align_data_s;
            tag0_s   = bus.in_tag;
            exc0_s   = align_exc_s;
            valid0_s = 1'b1;
`ifdef LOAD_ALIGN_PERF_EN
            ld0_s    = (bus.L_S_SL != MODE_NONE);
`endif
         end else begin
            valid0_s = 1'b0;
         end
      end else if (accept_s) begin
         data1_s  = align_data_s;
         tag1_s   = bus.in_tag;
         exc1_s   = align_exc_s;
         valid1_s = 1'b1;
`ifdef LOAD_ALIGN_PERF_EN
         ld1_s    = (bus.L_S_SL != MODE_NONE);
`endif
      end else begin
         valid1_s = valid1_r;
      end
   end

   // FIFO state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data0_r  <= {DATA_W{1'b0}};
         tag0_r   <= {TAG_W{1'b0}};
         exc0_r   <= 1'b0;
         valid0_r <= 1'b0;
         data1_r  <= {DATA_W{1'b0}};
         tag1_r   <= {TAG_W{1'b0}};
         exc1_r   <= 1'b0;
         valid1_r <= 1'b0;
      end else begin
         data0_r  <= data0_s;
         tag0_r   <= tag0_s;
         exc0_r   <= exc0_s;
         valid0_r <= valid0_s;
         data1_r  <= data1_s;
         tag1_r   <= tag1_s;
         exc1_r   <= exc1_s;
         valid1_r <= valid1_s;
      end
   end

   assign bus.in_ready  = !valid1_r;
   assign bus.out_valid = valid0_r;
   assign bus.DM_data   = data0_r;
   assign bus.out_tag   = tag0_r;
   assign bus.exc_adel  = exc0_r;

`ifdef LOAD_ALIGN_PERF_EN
   // Per-entry "real load" flag and saturating pop counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld0_r    <= 1'b0;
         ld1_r    <= 1'b0;
         load_cnt <= 16'h0000;
         adel_cnt <= 16'h0000;
      end else begin
         ld0_r <= ld0_s;
         ld1_r <= ld1_s;
         if (pop_s && ld0_r && (load_cnt != 16'hFFFF)) begin
            load_cnt <= load_cnt + 16'h0001;
         end
         if (pop_s && exc0_r && (adel_cnt != 16'hFFFF)) begin
            adel_cnt <= adel_cnt + 16'h0001;
         end
      end
   end
`endif
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Registered, parametrised successor to the combinational load-extension logic.
- Sits between data-memory read data and the writeback stage.
- Selects byte/half/word/(double) lanes from a DATA_W-wide memory word and sign- or zero-extends the selected lane.
- Flags misaligned or illegal loads and moves results through a valid/ready handshake with a 2-entry skid buffer, so writeback back-pressure never drops a load.

Parameters:
- DATA_W, 32: memory/register width. Legal values are 32 and 64 only.
- TAG_W, 5: width of the destination-register tag carried with each load.
- OFF_W, derived as log2(DATA_W/8): byte-offset width. Localparam, not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush; empties the buffer
- in_valid  in  1  a load result is presented
- in_ready  out  1  unit can accept this cycle
- mem_out  in  DATA_W  raw memory word
- L_S_SL  in  3  load mode, encoded as: 0 NONE, 1 B, 2 BU, 3 H, 4 HU, 5 W, 6 WU, 7 D
- DMAddr  in  OFF_W  byte offset within the word
- in_tag  in  TAG_W  destination register
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts this cycle
- DM_data  out  DATA_W  extended load data
- out_tag  out  TAG_W  tag of the presented result
- exc_adel  out  1  address-error-on-load for the presented result

Behaviour:
- Storage: output register (entry 0) plus skid register (entry 1). The unit behaves as a 2-deep FIFO. Combinational alignment is applied before storage, so each entry holds {data, tag, exc}.
- Reset (asynchronous): out_valid=0, DM_data=0, out_tag=0, exc_adel=0, and the skid is empty.
- in_ready = !skid_full. This is a registered-state function only; there is no combinational path from out_ready.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Latency: accepted data appears on the DM_data/out_valid outputs on the next rising edge when entry 0 is empty or popping in the same cycle. Otherwise it goes to the skid and advances to entry 0 on the edge after the pop.
- Ordering is strict FIFO. Simultaneous accept and pop with both entries valid cannot occur, because in_ready=0 in that state.
- Lane selection: lane = DMAddr scaled by mode size.
  - B/BU: byte DMAddr.
  - H/HU: half DMAddr[OFF_W-1:1].
  - W/WU: word DMAddr[OFF_W-1:2] (always word 0 when DATA_W=32).
  - D: the full word.
- Extension: B, H and W sign-extend to DATA_W. BU, HU and WU zero-extend. D passes through.
- Illegal/misaligned loads set exc=1 and force data=0. A load is illegal/misaligned when:
  - H/HU with DMAddr[0]≠0;
  - W/WU with DMAddr[1:0]≠0;
  - D with DMAddr≠0;
  - WU or D when DATA_W=32.
- NONE: data=0, exc=0. The entry is still accepted and tagged, for bubble-free pipelines.
- flush: on the next edge both entries are invalidated and out_valid=0. Flush overrides a same-cycle accept; the accepted word is discarded. in_ready is 1 the cycle after.
- Outputs hold stable while out_valid && !out_ready. This is a handshake invariant checked by assertion.
- Reset asserted mid-transfer immediately clears out_valid and the skid. No partial state survives.

Optional Feature:
- Macro: LOAD_ALIGN_PERF_EN.
- When defined, two outputs are added:
  - load_cnt [15:0]: increments on every pop with mode≠NONE.
  - adel_cnt [15:0]: increments on every pop with exc=1.
- Both counters saturate at 16'hFFFF, are cleared by reset, and are not cleared by flush.
- When undefined, the ports and counters are absent and the logic is otherwise identical.

Test Plan:
- DATA_W=32, mem_out=32'h80FF7F01, B with DMAddr=3 → DM_data=32'hFFFFFF80. BU with DMAddr=3 → 32'h00000080. H with DMAddr=2 → 32'hFFFF80FF. Each appears 1 cycle after accept, exc_adel=0.
- H with DMAddr=1 → exc_adel=1, DM_data=0, out_tag echoes in_tag=5'd9. WU with DATA_W=32 → exc_adel=1.
- DATA_W=64, mem_out=64'h8000_0001_7FFF_FFFF:
  - W with DMAddr=4 → 64'hFFFFFFFF80000001.
  - WU with DMAddr=4 → 64'h0000000080000001.
  - D with DMAddr=0 → passthrough.
- Back-pressure: out_ready=0, accept tags 1 then 2 → in_ready falls after the 2nd accept. Raise out_ready → tags pop 1 then 2 in order, with no loss or duplicate.
- Flush with both entries full plus in_valid=1 → next cycle out_valid=0, in_ready=1, and no stale tag appears afterwards.
- With LOAD_ALIGN_PERF_EN: 3 good loads plus 1 misaligned load popped → load_cnt=4, adel_cnt=1. Preload to 16'hFFFF → holds at 16'hFFFF.
